lsu_rsp_rr_arb: RTL



---
 rtl/lsu_rsp_rr_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/lsu_rsp_rr_arb.sv
// Two-input round-robin arbiter that merges dcache (in0) and shared-memory (in1)
// responses into the MSHR response port through a single output register stage.
module lsu_rsp_rr_arb #(
  parameter int IDW        = 4,
  parameter int NUM_THREAD = 32,
  parameter int DATAW      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  in0_valid_i,
  output logic                  in0_ready_o,
  input  logic [IDW-1:0]        in0_instrid_i,
  input  logic [DATAW-1:0]      in0_data_i,
  input  logic [NUM_THREAD-1:0] in0_activemask_i,

  input  logic                  in1_valid_i,
  output logic                  in1_ready_o,
  input  logic [IDW-1:0]        in1_instrid_i,
  input  logic [DATAW-1:0]      in1_data_i,
  input  logic [NUM_THREAD-1:0] in1_activemask_i,

  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [IDW-1:0]        out_instrid_o,
  output logic [DATAW-1:0]      out_data_o,
  output logic [NUM_THREAD-1:0] out_activemask_o,

  output logic                  prio_o
);

  logic                  load_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  xfer0_s;
  logic                  xfer1_s;
  logic                  prio_r;
  logic                  out_valid_r;
  logic [IDW-1:0]        out_instrid_r;
  logic [DATAW-1:0]      out_data_r;
  logic [NUM_THREAD-1:0] out_activemask_r;

  // Grant selection: a lone requester wins outright, a tie goes to the favoured input.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (in0_valid_i && in1_valid_i) begin
      grant0_s = ~prio_r;
      grant1_s = prio_r;
    end else begin
      grant0_s = in0_valid_i;
      grant1_s = in1_valid_i;
    end
  end

  // The slot can accept when empty or being drained; nothing is accepted during reset.
  assign load_s      = ~out_valid_r | out_ready_i;
  assign in0_ready_o = load_s & grant0_s & ~rst;
  assign in1_ready_o = load_s & grant1_s & ~rst;
  assign xfer0_s     = in0_valid_i & in0_ready_o;
  assign xfer1_s     = in1_valid_i & in1_ready_o;

  // Output register stage and round-robin priority; the winner becomes least favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r      <= 1'b0;
      out_instrid_r    <= '0;
      out_data_r       <= '0;
      out_activemask_r <= '0;
      prio_r           <= 1'b0;
    end else if (xfer0_s) begin
      out_valid_r      <= 1'b1;
      out_instrid_r    <= in0_instrid_i;
      out_data_r       <= in0_data_i;
      out_activemask_r <= in0_activemask_i;
      prio_r           <= 1'b1;
    end else if (xfer1_s) begin
      out_valid_r      <= 1'b1;
      out_instrid_r    <= in1_instrid_i;
      out_data_r       <= in1_data_i;
      out_activemask_r <= in1_activemask_i;
      prio_r           <= 1'b0;
    end else if (out_ready_i) begin
      out_valid_r      <= 1'b0;
    end else begin
      out_valid_r      <= out_valid_r;
    end
  end

  assign out_valid_o      = out_valid_r;
  assign out_instrid_o    = out_instrid_r;
  assign out_data_o       = out_data_r;
  assign out_activemask_o = out_activemask_r;
  assign prio_o           = prio_r;

endmodule
